multicycle_ctrl: RTL and testbench

Main control FSM of the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath control: PC write, IR write, memory request, register-file write enable, and the write-back and next-PC selects. Sits between the instruction register and the shared single-port memory interface. Traps illegal opcodes and memory timeouts into a halted state.

---
 rtl/rv_ctrl_pkg.sv | 45 ++++
 rtl/opcode_class_dec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, state/class enums and select encodings for the RV32I control FSM
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } cls_t;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;
    localparam logic [1:0] PC_SRC_JAL    = 2'b11;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

endpackage

// File: rtl/opcode_class_dec.sv
// rtl/opcode_class_dec.sv - combinational opcode-to-class decoder with a valid flag
module opcode_class_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_cls,
    output logic       o_valid
);

    always_comb begin
        o_cls   = CLS_R;
        o_valid = 1'b1;
        case (i_opcode)
            OP_R:      o_cls = CLS_R;
            OP_I_ALU:  o_cls = CLS_I_ALU;
            OP_LOAD:   o_cls = CLS_LOAD;
            OP_STORE:  o_cls = CLS_STORE;
            OP_BRANCH: o_cls = CLS_BRANCH;
            OP_LUI:    o_cls = CLS_LUI;
            OP_AUIPC:  o_cls = CLS_AUIPC;
            OP_JAL:    o_cls = CLS_JAL;
            OP_JALR:   o_cls = CLS_JALR;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write_en,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    cls_t               r_cls;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_illegal;
    logic               r_bus_err;
    logic [3:0]         w_dec_cls;
    logic               w_dec_valid;
    logic               w_timeout;
    logic               w_set_illegal;
    logic               w_set_bus_err;

    opcode_class_dec u_dec (
        .i_opcode (opcode),
        .o_cls    (w_dec_cls),
        .o_valid  (w_dec_valid)
    );

    // The cycle that finds the counter already at MEM_WAIT_MAX is the (MAX+1)-th wait.
    assign w_timeout = (r_wait_cnt == CNT_W'(MEM_WAIT_MAX));

    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        reg_write_en  = 1'b0;
        wb_sel        = WB_SEL_ALU;
        halted        = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (w_dec_valid) begin
                    w_next = ST_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                        w_next   = ST_FETCH;
                    end
                    default: w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_cls == CLS_STORE);
                if (mem_ready) begin
                    if (r_cls == CLS_STORE) begin
                        pc_write = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                w_next       = ST_FETCH;
                case (r_cls)
                    CLS_LOAD: wb_sel = WB_SEL_MEM;
                    CLS_JAL: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_JAL;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_JALR;
                    end
                    default: ;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: w_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cls      <= CLS_R;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE && w_dec_valid) begin
                r_cls <= cls_t'(w_dec_cls);
            end
            if (w_next != r_state || mem_ready) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int MW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0] pc_src, wb_sel;
    logic       reg_write_en, halted, illegal_instr, bus_error;
    logic [2:0] state_dbg;
    logic [15:0] w_outs;

    int total = 0;
    int bad = 0;

    multicycle_ctrl #(.MEM_WAIT_MAX(MW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write_en(reg_write_en), .wb_sel(wb_sel),
        .halted(halted), .illegal_instr(illegal_instr), .bus_error(bus_error),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign w_outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                     reg_write_en, wb_sel, halted, illegal_instr, bus_error, state_dbg};

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       tk;
        int         cycles;
        logic       rwe;
        logic [1:0] wb;
        logic [1:0] pcs;
        logic       we;
    } vec_t;

    typedef struct packed {
        logic        rdy;
        logic        tk;
        logic [15:0] exp;
    } cyc_t;

    cyc_t q[$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic req, we, as, irw, pcw, input logic [1:0] pcs,
                                       input logic rwe, input logic [1:0] wb,
                                       input logic h, il, be, input logic [2:0] st);
        return {req, we, as, irw, pcw, pcs, rwe, wb, h, il, be, st};
    endfunction

    task automatic push(input logic rdy, input logic tk, input logic [15:0] e);
        cyc_t c;
        c = {rdy, tk, e};
        q.push_back(c);
    endtask

    // Expected per-cycle trace of one instruction, written straight from the instruction-class rules.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic tk);
        logic ld, st, br, lg;
        logic [1:0] wb, pcs;
        ld = 0; st = 0; br = 0; lg = 1; wb = 2'b00; pcs = 2'b00;
        case (op)
            7'b0000011: begin ld = 1; wb = 2'b01; end
            7'b0100011: st = 1;
            7'b1100011: br = 1;
            7'b1101111: begin wb = 2'b10; pcs = 2'b11; end
            7'b1100111: begin wb = 2'b10; pcs = 2'b10; end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: ;
            default: lg = 0;
        endcase
        for (int i = 0; i < fw; i++) push(1'b0, 1'($urandom), pk(1,0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        push(1'b1, 1'($urandom), pk(1,0,0,1,0,2'b00,0,2'b00,0,0,0,3'd1));
        push(1'($urandom), 1'($urandom), pk(0,0,0,0,0,2'b00,0,2'b00,0,0,0,3'd2));
        if (!lg) begin
            for (int i = 0; i < 4; i++)
                push(1'($urandom), 1'($urandom), pk(0,0,0,0,0,2'b00,0,2'b00,1,1,0,3'd6));
            return;
        end
        if (br) begin
            push(1'($urandom), tk, pk(0,0,0,0,1,{1'b0, tk},0,2'b00,0,0,0,3'd3));
            return;
        end
        push(1'($urandom), 1'($urandom), pk(0,0,0,0,0,2'b00,0,2'b00,0,0,0,3'd3));
        if (ld || st) begin
            for (int i = 0; i < mw; i++) push(1'b0, 1'($urandom), pk(1,st,1,0,0,2'b00,0,2'b00,0,0,0,3'd4));
            push(1'b1, 1'($urandom), pk(1,st,1,0,st,2'b00,0,2'b00,0,0,0,3'd4));
        end
        if (!st) push(1'($urandom), 1'($urandom), pk(0,0,0,0,1,pcs,1,wb,0,0,0,3'd5));
    endtask

    task automatic apply(input string nm);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready    = c.rdy;
            branch_taken = c.tk;
            @(negedge clk);
            check(nm, w_outs, c.exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", w_outs, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_state", {13'd0, state_dbg}, 16'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, fcnt, mcnt;
        logic [2:0] st;
        logic rwe_seen, we_seen, done;
        logic [1:0] wb_seen, pcs_seen;
        cyc = 0; fcnt = 0; mcnt = 0; done = 0;
        rwe_seen = 0; we_seen = 0; wb_seen = 2'b00; pcs_seen = 2'b00;
        opcode = v.op;
        branch_taken = v.tk;
        for (int i = 0; i < 40 && !done; i++) begin
            st = state_dbg;
            mem_ready = (st == 3'd1) ? (fcnt == v.fw) : (st == 3'd4) ? (mcnt == v.mw) : 1'b0;
            @(negedge clk);
            if (reg_write_en) begin rwe_seen = 1; wb_seen = wb_sel; end
            if (pc_write) pcs_seen = pc_src;
            if (mem_req && mem_we) we_seen = 1;
            if (st == 3'd1 && !mem_ready) fcnt++;
            if (st == 3'd4 && !mem_ready) mcnt++;
            cyc++;
            @(posedge clk);
            #1;
            if (state_dbg == 3'd1 && st != 3'd1) done = 1;
        end
        check($sformatf("vec%0d_done", idx), {15'd0, done}, 16'd1);
        check($sformatf("vec%0d_cycles", idx), 16'(cyc), 16'(v.cycles));
        check($sformatf("vec%0d_regwrite", idx), {15'd0, rwe_seen}, {15'd0, v.rwe});
        check($sformatf("vec%0d_wbsel", idx), {14'd0, wb_seen}, {14'd0, v.wb});
        check($sformatf("vec%0d_pcsrc", idx), {14'd0, pcs_seen}, {14'd0, v.pcs});
        check($sformatf("vec%0d_memwe", idx), {15'd0, we_seen}, {15'd0, v.we});
    endtask

    vec_t vecs[11];
    logic [6:0] legal_ops[9];

    initial begin
        vecs[0]  = '{7'b0010011, 0, 0, 1'b0, 4,  1'b1, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{7'b0000011, 0, 2, 1'b0, 7,  1'b1, 2'b01, 2'b00, 1'b0};
        vecs[2]  = '{7'b0100011, 0, 0, 1'b0, 4,  1'b0, 2'b00, 2'b00, 1'b1};
        vecs[3]  = '{7'b1100011, 0, 0, 1'b1, 3,  1'b0, 2'b00, 2'b01, 1'b0};
        vecs[4]  = '{7'b1100011, 0, 0, 1'b0, 3,  1'b0, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{7'b1100111, 0, 0, 1'b0, 4,  1'b1, 2'b10, 2'b10, 1'b0};
        vecs[6]  = '{7'b1101111, 0, 0, 1'b0, 4,  1'b1, 2'b10, 2'b11, 1'b0};
        vecs[7]  = '{7'b0110111, 1, 0, 1'b0, 5,  1'b1, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{7'b0010111, 0, 0, 1'b0, 4,  1'b1, 2'b00, 2'b00, 1'b0};
        vecs[9]  = '{7'b0110011, 4, 0, 1'b0, 8,  1'b1, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{7'b0000011, 1, 4, 1'b0, 10, 1'b1, 2'b01, 2'b00, 1'b0};
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

        do_reset();
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = legal_ops[$urandom_range(0, 8)];
            opcode = op;
            build(op, $urandom_range(0, MW - 1), $urandom_range(0, MW), 1'($urandom));
            apply($sformatf("rand%0d_op%b", n, op));
        end

        do_reset();
        opcode = 7'b1111111;
        build(7'b1111111, 0, 0, 1'b0);
        apply("illegal_halt");

        do_reset();
        opcode = 7'b0010011;
        for (int i = 0; i <= MW; i++) push(1'b0, 1'($urandom), pk(1,0,0,0,0,2'b00,0,2'b00,0,0,0,3'd1));
        for (int i = 0; i < 3; i++) push(1'($urandom), 1'($urandom), pk(0,0,0,0,0,2'b00,0,2'b00,1,0,1,3'd6));
        apply("fetch_timeout");

        do_reset();
        opcode = 7'b0000011;
        build(7'b0000011, 0, MW, 1'b0);
        apply("load_max_wait");
        mem_ready = 1'b0;
        #1;
        check("fetch_req_before_rst", {15'd0, mem_req}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_drops_req", w_outs, 16'h0000);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
